// File: rtl/fsm_byte_scan_ctrl.sv
// Shifts a parallel message MSB-first through a 4-state Mealy pattern FSM and returns the
// per-bit output mask plus its popcount. Build option: FSM_BYTE_SCAN_CARRY_EN (pattern state carries over).
module fsm_byte_scan_ctrl #(
  parameter int NBITS = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_mask,
  output logic [CW-1:0]    out_cnt,
  output logic [1:0]       pat_state
);

  localparam int IW = $clog2(NBITS);

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_SCAN = 2'd1,
    CTRL_DONE = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PAT_A = 2'd0,
    PAT_B = 2'd1,
    PAT_C = 2'd2,
    PAT_D = 2'd3
  } pat_state_e;

  ctrl_state_e      r_ctrl;
  pat_state_e       r_pat;
  logic [NBITS-1:0] r_msg;
  logic [NBITS-1:0] r_mask;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;

  logic             w_bit;
  pat_state_e       w_pat_nxt;
  logic             w_pat_out;

  assign w_bit = r_msg[r_idx];

  always_comb begin
    // NOTE: defaults before the case so every path assigns both outputs -- no latch.
    w_pat_nxt = r_pat;
    w_pat_out = 1'b0;
    case (r_pat)
      PAT_A: begin
        w_pat_nxt = w_bit ? PAT_B : PAT_A;
        w_pat_out = w_bit;
      end
      PAT_B: begin
        w_pat_nxt = w_bit ? PAT_B : PAT_C;
        w_pat_out = ~w_bit;
      end
      PAT_C: begin
        w_pat_nxt = w_bit ? PAT_D : PAT_A;
        w_pat_out = w_bit;
      end
      PAT_D: begin
        w_pat_nxt = w_bit ? PAT_B : PAT_C;
        w_pat_out = 1'b0;
      end
      default: begin
        w_pat_nxt = PAT_A;
        w_pat_out = 1'b0;
      end
    endcase
  end

  // NOTE: non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= CTRL_IDLE;
      r_pat  <= PAT_A;
      r_msg  <= '0;
      r_mask <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
    end else begin
      case (r_ctrl)
        CTRL_IDLE: begin
          if (in_val) begin
            r_msg  <= in_msg;
            r_idx  <= IW'(NBITS - 1);
            r_mask <= '0;
            r_cnt  <= '0;
`ifdef FSM_BYTE_SCAN_CARRY_EN
            r_pat  <= r_pat;
`else
            r_pat  <= PAT_A;
`endif
            r_ctrl <= CTRL_SCAN;
          end
        end
        CTRL_SCAN: begin
          r_pat         <= w_pat_nxt;
          r_mask[r_idx] <= w_pat_out;
          r_cnt         <= r_cnt + CW'(w_pat_out);
          if (r_idx == '0) begin
            r_ctrl <= CTRL_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        CTRL_DONE: begin
          if (out_rdy) begin
            r_ctrl <= CTRL_IDLE;
          end
        end
        default: r_ctrl <= CTRL_IDLE;
      endcase
    end
  end

  // Handshake flags depend only on registered state and reset, never on in_val/out_rdy.
  assign in_rdy    = (r_ctrl == CTRL_IDLE) && !reset;
  assign out_val   = (r_ctrl == CTRL_DONE) && !reset;
  assign out_mask  = r_mask;
  assign out_cnt   = r_cnt;
  assign pat_state = r_pat;

endmodule

// File: tb/tb_fsm_byte_scan_ctrl.sv
// Bench for fsm_byte_scan_ctrl: message-level reference model checked every cycle, plus
// directed scenarios with literal expectations. Honors FSM_BYTE_SCAN_CARRY_EN when defined.
module tb_fsm_byte_scan_ctrl;

  localparam int NBITS = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             reset;
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_msg;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_mask;
  logic [CW-1:0]    out_cnt;
  logic [1:0]       pat_state;

  fsm_byte_scan_ctrl #(.NBITS(NBITS), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_mask  (out_mask),
    .out_cnt   (out_cnt),
    .pat_state (pat_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int t_hs  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pattern machine as lookup tables indexed [state][input bit]; A=0 B=1 C=2 D=3.
  int nxt_tbl [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};
  int out_tbl [4][2] = '{'{0, 1}, '{1, 0}, '{0, 1}, '{0, 0}};

  // Result after the first k bits (MSB first) of msg have been scanned from state start.
  function automatic void scan_prefix(input logic [NBITS-1:0] msg, input int start, input int k,
                                      output logic [NBITS-1:0] mask, output int cnt,
                                      output int pat);
    mask = '0;
    cnt  = 0;
    pat  = start;
    for (int i = 0; i < k; i++) begin
      int idx;
      int b;
      int o;
      idx = NBITS - 1 - i;
      b   = int'(msg[idx]);
      o   = out_tbl[pat][b];
      mask[idx] = o[0];
      cnt += o;
      pat = nxt_tbl[pat][b];
    end
  endfunction

  // Message-level model: active message, bits consumed so far, and what idle outputs show.
  bit               m_active    = 1'b0;
  int               m_k         = 0;
  logic [NBITS-1:0] m_msg       = '0;
  int               m_start     = 0;
  logic [NBITS-1:0] m_idle_mask = '0;
  int               m_idle_cnt  = 0;
  int               m_idle_pat  = 0;

  always @(negedge clk) begin
    logic [NBITS-1:0] em;
    int ec;
    int ep;
    if (m_active) begin
      scan_prefix(m_msg, m_start, m_k, em, ec, ep);
    end else begin
      em = m_idle_mask;
      ec = m_idle_cnt;
      ep = m_idle_pat;
    end
    check("in_rdy",    in_rdy,    !m_active && !reset);
    check("out_val",   out_val,   m_active && (m_k == NBITS) && !reset);
    check("out_mask",  out_mask,  em);
    check("out_cnt",   out_cnt,   ec);
    check("pat_state", pat_state, ep);

    // Advance the model to what the next rising edge produces.
    if (reset) begin
      m_active    = 1'b0;
      m_idle_mask = '0;
      m_idle_cnt  = 0;
      m_idle_pat  = 0;
    end else if (!m_active) begin
      if (in_val) begin
        m_active = 1'b1;
        m_k      = 0;
        m_msg    = in_msg;
`ifdef FSM_BYTE_SCAN_CARRY_EN
        m_start  = m_idle_pat;
`else
        m_start  = 0;
`endif
      end
    end else if (m_k < NBITS) begin
      m_k++;
    end else if (out_rdy) begin
      m_active    = 1'b0;
      m_idle_mask = em;
      m_idle_cnt  = ec;
      m_idle_pat  = ep;
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset  = 1'b1;
    in_val = 1'b0;
    @(posedge clk); #1;
    reset  = 1'b0;
  endtask

  task automatic send(input logic [NBITS-1:0] msg);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_val = 1'b1;
    in_msg = msg;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_rdy) begin
        ok   = 1'b1;
        t_hs = cyc;
        break;
      end
    end
    check("send_accepted", ok, 1);
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [NBITS-1:0] em, input int ec,
                             input int ep);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_val) begin
        got = 1'b1;
        lat = cyc - t_hs;
        break;
      end
    end
    check({tag, "_seen"},    got,       1);
    check({tag, "_latency"}, lat,       NBITS + 1);
    check({tag, "_mask"},    out_mask,  em);
    check({tag, "_cnt"},     out_cnt,   ec);
    check({tag, "_pat"},     pat_state, ep);
  endtask

  task automatic run_one(input string tag, input logic [NBITS-1:0] msg,
                         input logic [NBITS-1:0] em, input int ec, input int ep);
    send(msg);
    wait_result(tag, em, ec, ep);
  endtask

  initial begin
    reset   = 1'b1;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_rdy", in_rdy,    1);
    check("rst_mask",   out_mask,  0);
    check("rst_cnt",    out_cnt,   0);
    check("rst_pat",    pat_state, 0);

    apply_reset();
    run_one("alt55", 8'h55, 8'h75, 5, 3);

    apply_reset();
    run_one("runA0", 8'hA0, 8'hE0, 3, 0);

    apply_reset();
    run_one("carryFF", 8'hFF, 8'h80, 1, 1);
`ifdef FSM_BYTE_SCAN_CARRY_EN
    run_one("carry00", 8'h00, 8'h80, 1, 0);
`else
    run_one("carry00", 8'h00, 8'h00, 0, 0);
`endif

    // Backpressure: result must hold while out_rdy is low.
    apply_reset();
    out_rdy = 1'b0;
    run_one("bp", 8'h55, 8'h75, 5, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_val", out_val,  1);
      check("bp_in_rdy",  in_rdy,   0);
      check("bp_mask",    out_mask, 8'h75);
      check("bp_cnt",     out_cnt,  5);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_rdy", in_rdy, 1);

    // Reset three cycles into a scan aborts the message.
    apply_reset();
    send(8'h55);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_rdy", in_rdy,    1);
    check("abort_pat",    pat_state, 0);
    check("abort_mask",   out_mask,  0);
    check("abort_cnt",    out_cnt,   0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_val) seen = 1'b1;
      end
      check("abort_no_out_val", seen, 0);
    end
    run_one("after_abort", 8'h00, 8'h00, 0, 0);

    // Back-to-back with in_val held high.
    apply_reset();
    begin
      int               nhs;
      int               nres;
      int               rc [2];
      logic [NBITS-1:0] rm [2];
      logic [NBITS-1:0] exp2;
      nhs  = 0;
      nres = 0;
      rc   = '{0, 0};
      rm   = '{'0, '0};
`ifdef FSM_BYTE_SCAN_CARRY_EN
      exp2 = 8'h60;
`else
      exp2 = 8'hE0;
`endif
      @(posedge clk); #1;
      in_val = 1'b1;
      in_msg = 8'h55;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_val && nres < 2) begin
          rc[nres] = cyc;
          rm[nres] = out_mask;
          nres++;
        end
        if (in_rdy && in_val) begin
          nhs++;
          @(posedge clk); #1;
          if (nhs == 1) in_msg = 8'hA0;
          else          in_val = 1'b0;
        end
      end
      in_val = 1'b0;
      check("b2b_results", nres,          2);
      check("b2b_spacing", rc[1] - rc[0], NBITS + 2);
      check("b2b_mask0",   rm[0],         8'h75);
      check("b2b_mask1",   rm[1],         exp2);
    end

    // Randomized traffic: the per-cycle model compare does all the checking.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      in_val  = 1'($urandom_range(0, 1));
      in_msg  = NBITS'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    reset   = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b1;
    repeat (NBITS + 4) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
